// File: rtl/ipg_pkg.sv
// Shared IPG message definitions: source indices, block-type codes and helpers.
// Also used by the TX IPG inserter and the far-end request processors.
package ipg_pkg;

  localparam int unsigned NUM_SRC = 3;

  localparam logic [1:0] SRC_READ   = 2'd0;
  localparam logic [1:0] SRC_RRESP  = 2'd1;
  localparam logic [1:0] SRC_WRITE  = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'd3;

  localparam logic [7:0] READFIRST  = 8'h0a;
  localparam logic [7:0] RRESPFIRST = 8'h0b;
  localparam logic [7:0] WRITFIRST  = 8'h0c;
  localparam logic [7:0] READMID    = 8'h1a;
  localparam logic [7:0] RRESPMID   = 8'h1b;
  localparam logic [7:0] WRITMID    = 8'h1c;
  localparam logic [7:0] READLAST   = 8'h2a;
  localparam logic [7:0] RRESPLAST  = 8'h2b;
  localparam logic [7:0] WRITLAST   = 8'h2c;

  typedef enum logic [1:0] {
    BLK_FIRST,
    BLK_MID,
    BLK_LAST
  } blk_kind_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } arb_state_e;

  // Block-type byte for a given source and position inside its message.
  function automatic logic [7:0] blk_type(input logic [1:0] src, input blk_kind_e kind);
    logic [7:0] t;
    t = READFIRST;
    case (src)
      SRC_RRESP: t = (kind == BLK_FIRST) ? RRESPFIRST : (kind == BLK_MID) ? RRESPMID : RRESPLAST;
      SRC_WRITE: t = (kind == BLK_FIRST) ? WRITFIRST  : (kind == BLK_MID) ? WRITMID  : WRITLAST;
      default:   t = (kind == BLK_FIRST) ? READFIRST  : (kind == BLK_MID) ? READMID  : READLAST;
    endcase
    return t;
  endfunction

  // Round-robin successor: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] src);
    return (src >= SRC_WRITE) ? SRC_READ : src + 2'd1;
  endfunction

endpackage

// File: rtl/ipg_rr_pick.sv
// 3-way round-robin selector (combinational).
//   ptr_i     : highest-priority source this round
//   valid_i   : per-source request vector
//   sel_c_o   : first valid source at or after ptr_i (0 when none)
//   any_c_o   : at least one source is valid
module ipg_rr_pick
  import ipg_pkg::*;
(
  input  logic [1:0]         ptr_i,
  input  logic [NUM_SRC-1:0] valid_i,
  output logic [1:0]         sel_c_o,
  output logic               any_c_o
);

  logic [2:0] idx;
  logic       found;

  // Scan ptr, ptr+1, ptr+2 (mod 3) and keep the first hit.
  always_comb begin
    sel_c_o = SRC_READ;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = 3'(ptr_i) + 3'(k);
      if (idx >= 3'(NUM_SRC)) idx = idx - 3'(NUM_SRC);
      if (!found && valid_i[idx[1:0]]) begin
        sel_c_o = idx[1:0];
        found   = 1'b1;
      end
    end
  end

  assign any_c_o = |valid_i;

endmodule

// File: rtl/ipg_msg_arbiter.sv
// Shares the IPG transmit slot stream between READ, RRESP and WRITE message
// sources. One source owns the stream per message; each accepted 56-bit
// payload block goes out one cycle later with its block-type byte prepended.
//   clk, reset    : clock, synchronous active-high reset
//   ipg_slot      : PHY offers an IPG slot this cycle
//   req_valid/data/last : per-source block handshake (data flattened, 56b each)
//   req_ready     : block accepted this cycle (combinational)
//   ipg_tx_data/valid   : registered outgoing IPG block
//   grant         : current owner, 3 when idle
//   abort         : one-cycle pulse when a stalled message is dropped
//   err_sticky    : protocol error seen since reset
module ipg_msg_arbiter
  import ipg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BLKS   = 16,
  parameter int unsigned STALL_MAX  = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                ipg_slot,
  input  logic [NUM_SRC-1:0]                  req_valid,
  input  logic [NUM_SRC*(DATA_WIDTH-8)-1:0]   req_data,
  input  logic [NUM_SRC-1:0]                  req_last,
  output logic [NUM_SRC-1:0]                  req_ready,
  output logic [DATA_WIDTH-1:0]               ipg_tx_data,
  output logic                                ipg_tx_valid,
  output logic [1:0]                          grant,
  output logic                                abort,
  output logic                                err_sticky
);

  localparam int unsigned PAY_W     = DATA_WIDTH - 8;
  localparam int unsigned CNT_LIMIT = (MAX_BLKS > STALL_MAX) ? MAX_BLKS : STALL_MAX;

  // Counters must be able to reach both the block cap and the stall limit.
  if ((64'd1 << CNT_W) <= 64'(CNT_LIMIT)) begin : g_cnt_w_check
    $error("ipg_msg_arbiter: CNT_W too narrow for MAX_BLKS/STALL_MAX");
  end

  arb_state_e            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [CNT_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0]      stall_q, stall_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  abort_q, abort_d;
  logic                  err_q, err_d;

  logic [1:0]            pick_sel;
  logic                  pick_any;
  logic [1:0]            cur_src;
  logic [NUM_SRC:0]      valid_pad, last_pad;
  logic                  cur_valid, cur_last;
  logic [PAY_W-1:0]      cur_pay;
  logic                  accept;
  logic                  at_cap;
  logic [CNT_W-1:0]      stall_inc;

  ipg_rr_pick u_rr_pick (
    .ptr_i   (ptr_q),
    .valid_i (req_valid),
    .sel_c_o (pick_sel),
    .any_c_o (pick_any)
  );

  // Source under consideration: RR winner when idle, owner when busy.
  assign cur_src   = (state_q == ST_IDLE) ? pick_sel : grant_q;
  assign valid_pad = {1'b0, req_valid};
  assign last_pad  = {1'b0, req_last};
  assign cur_valid = valid_pad[cur_src];
  assign cur_last  = last_pad[cur_src];
  assign accept    = ipg_slot & ((state_q == ST_IDLE) ? pick_any : cur_valid);
  assign at_cap    = (blk_cnt_q == CNT_W'(MAX_BLKS - 1));
  assign stall_inc = stall_q + CNT_W'(1);

  // Payload mux for the current source.
  always_comb begin
    case (cur_src)
      SRC_RRESP: cur_pay = req_data[PAY_W +: PAY_W];
      SRC_WRITE: cur_pay = req_data[2*PAY_W +: PAY_W];
      default:   cur_pay = req_data[0 +: PAY_W];
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      req_ready[i] = accept && (cur_src == 2'(i));
    end
  end

  // Next-state, counters and output block.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    blk_cnt_d  = blk_cnt_q;
    stall_d    = stall_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    abort_d    = 1'b0;
    err_d      = err_q;

    if (state_q == ST_IDLE) begin
      if (accept) begin
        tx_valid_d = 1'b1;
        tx_data_d  = {cur_pay, blk_type(cur_src, BLK_FIRST)};
        if (cur_last) begin
          // Single-block message: flag it and release immediately.
          err_d = 1'b1;
          ptr_d = rr_next(cur_src);
        end else begin
          state_d   = ST_BUSY;
          grant_d   = cur_src;
          blk_cnt_d = CNT_W'(1);
          stall_d   = '0;
        end
      end
    end else begin
      if (accept) begin
        tx_valid_d = 1'b1;
        stall_d    = '0;
        if (at_cap || cur_last) begin
          // Cap forces LAST; remaining blocks re-arbitrate as a new message.
          tx_data_d = {cur_pay, blk_type(grant_q, BLK_LAST)};
          if (!cur_last) err_d = 1'b1;
          state_d   = ST_IDLE;
          grant_d   = GRANT_NONE;
          ptr_d     = rr_next(grant_q);
          blk_cnt_d = '0;
        end else begin
          tx_data_d = {cur_pay, blk_type(grant_q, BLK_MID)};
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
        end
      end else if (ipg_slot) begin
        // Only offered-but-unused slots count toward the stall limit.
        stall_d = stall_inc;
        if (stall_inc == CNT_W'(STALL_MAX)) begin
          abort_d   = 1'b1;
          state_d   = ST_IDLE;
          grant_d   = GRANT_NONE;
          ptr_d     = rr_next(grant_q);
          blk_cnt_d = '0;
          stall_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= GRANT_NONE;
      ptr_q      <= SRC_READ;
      blk_cnt_q  <= '0;
      stall_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      blk_cnt_q  <= blk_cnt_d;
      stall_q    <= stall_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
    end
  end

  assign ipg_tx_data  = tx_data_q;
  assign ipg_tx_valid = tx_valid_q;
  assign grant        = grant_q;
  assign abort        = abort_q;
  assign err_sticky   = err_q;

endmodule

// File: tb/tb_ipg_msg_arbiter.sv
// Bench for ipg_msg_arbiter, built with a 4-block cap and a 3-slot stall limit.
module tb_ipg_msg_arbiter;

  localparam int unsigned DW   = 64;
  localparam int unsigned PW   = 56;
  localparam int unsigned MAXB = 4;
  localparam int unsigned STLM = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            ipg_slot;
  logic [2:0]      req_valid;
  logic [3*PW-1:0] req_data;
  logic [2:0]      req_last;
  logic [2:0]      req_ready;
  logic [DW-1:0]   ipg_tx_data;
  logic            ipg_tx_valid;
  logic [1:0]      grant;
  logic            abort;
  logic            err_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ipg_msg_arbiter #(
    .DATA_WIDTH (DW),
    .MAX_BLKS   (MAXB),
    .STALL_MAX  (STLM),
    .CNT_W      (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ipg_slot     (ipg_slot),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .ipg_tx_data  (ipg_tx_data),
    .ipg_tx_valid (ipg_tx_valid),
    .grant        (grant),
    .abort        (abort),
    .err_sticky   (err_sticky)
  );

  // kind: 0 first, 1 middle, 2 last; class nibble a/b/c for source 0/1/2
  function automatic logic [7:0] exp_type(input int src, input int kind);
    return 8'(16 * kind + 10 + src);
  endfunction

  function automatic logic [PW-1:0] rnd_pay();
    return PW'({$urandom, $urandom});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pay(input int src, input logic [PW-1:0] p);
    req_data[src*PW +: PW] = p;
  endtask

  task automatic do_reset();
    reset = 1'b1; ipg_slot = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ipg_slot = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    tick(); tick();
    total++; if (ipg_tx_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", ipg_tx_data); end
    total++; if (ipg_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ipg_tx_valid); end
    total++; if (grant !== 2'd3) begin bad++; $display("FAIL reset_grant got=%0d exp=3", grant); end
    total++; if (abort !== 1'b0) begin bad++; $display("FAIL reset_abort got=%b exp=0", abort); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_sticky); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    reset = 1'b0; ipg_slot = 1'b0;
    tick();
  endtask

  task automatic test_single_source();
    logic [PW-1:0] p[4];
    logic [DW-1:0] e;
    int kind;
    for (int k = 0; k < 4; k++) p[k] = rnd_pay();
    for (int k = 0; k < 4; k++) begin
      ipg_slot = 1'b1; req_valid = 3'b100; req_last = (k == 3) ? 3'b100 : 3'b000;
      set_pay(2, p[k]);
      #1;
      total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL single_ready%0d got=%b exp=100", k, req_ready); end
      tick();
      kind = (k == 0) ? 0 : (k == 3) ? 2 : 1;
      e = {p[k], exp_type(2, kind)};
      total++; if (ipg_tx_valid !== 1'b1 || ipg_tx_data !== e) begin
        bad++; $display("FAIL single_blk%0d got=%b/%h exp=1/%h", k, ipg_tx_valid, ipg_tx_data, e); end
      total++; if (grant !== ((k == 3) ? 2'd3 : 2'd2)) begin
        bad++; $display("FAIL single_grant%0d got=%0d exp=%0d", k, grant, (k == 3) ? 3 : 2); end
    end
    e = {p[3], exp_type(2, 2)};
    req_valid = '0; req_last = '0;
    tick();
    total++; if (ipg_tx_valid !== 1'b0 || ipg_tx_data !== e) begin
      bad++; $display("FAIL single_hold got=%b/%h exp=0/%h", ipg_tx_valid, ipg_tx_data, e); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", err_sticky); end
  endtask

  task automatic test_slot_gating();
    logic [PW-1:0] p[3];
    logic [DW-1:0] e;
    int k;
    int kind;
    for (int i = 0; i < 3; i++) p[i] = rnd_pay();
    k = 0;
    for (int c = 0; c < 6; c++) begin
      ipg_slot = (c % 2 == 0); req_valid = 3'b010; req_last = (k == 2) ? 3'b010 : 3'b000;
      set_pay(1, p[k]);
      #1;
      total++; if (req_ready !== (ipg_slot ? 3'b010 : 3'b000)) begin
        bad++; $display("FAIL gate_ready%0d got=%b slot=%b", c, req_ready, ipg_slot); end
      tick();
      if (c % 2 == 0) begin
        kind = (k == 0) ? 0 : (k == 2) ? 2 : 1;
        e = {p[k], exp_type(1, kind)};
        total++; if (ipg_tx_valid !== 1'b1 || ipg_tx_data !== e) begin
          bad++; $display("FAIL gate_blk%0d got=%b/%h exp=1/%h", k, ipg_tx_valid, ipg_tx_data, e); end
        k++;
      end else begin
        total++; if (ipg_tx_valid !== 1'b0) begin bad++; $display("FAIL gate_idle%0d got=%b exp=0", c, ipg_tx_valid); end
      end
    end
    total++; if (grant !== 2'd3) begin bad++; $display("FAIL gate_grant got=%0d exp=3", grant); end
    req_valid = '0; req_last = '0; ipg_slot = 1'b0;
  endtask

  task automatic test_contention();
    logic [PW-1:0] pays[3][4];
    logic [DW-1:0] exp_q[$];
    int            src_q[$];
    int            kind_q[$];
    int            sent[3];
    int            nleft[3];
    int            ptr, s, cyc;
    logic [2:0]    rdy;
    logic [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sent[i] = 0; nleft[i] = 2;
      for (int b = 0; b < 4; b++) pays[i][b] = rnd_pay();
    end
    // Reference: each message goes to the first source at/after the pointer with work left.
    ptr = 0;
    while (nleft[0] + nleft[1] + nleft[2] > 0) begin
      s = -1;
      for (int k = 0; k < 3; k++) if (s < 0 && nleft[(ptr + k) % 3] > 0) s = (ptr + k) % 3;
      for (int b = 0; b < 2; b++) begin
        exp_q.push_back({pays[s][2 * (2 - nleft[s]) + b], exp_type(s, 2 * b)});
        src_q.push_back(s); kind_q.push_back(2 * b);
      end
      nleft[s]--; ptr = (s + 1) % 3;
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      ipg_slot = 1'b1;
      for (int i = 0; i < 3; i++) begin
        req_valid[i] = (sent[i] < 4);
        req_last[i]  = (sent[i] % 2 == 1);
        if (sent[i] < 4) set_pay(i, pays[i][sent[i]]);
      end
      #1;
      rdy = req_ready;
      total++; if (!$onehot0(rdy) || (rdy & ~req_valid) != 3'b000) begin
        bad++; $display("FAIL cont_ready cyc%0d got=%b valid=%b", cyc, rdy, req_valid); end
      tick();
      for (int i = 0; i < 3; i++) if (rdy[i]) sent[i]++;
      if (ipg_tx_valid) begin
        e = exp_q.pop_front(); s = src_q.pop_front();
        total++; if (ipg_tx_data !== e) begin bad++; $display("FAIL cont_blk cyc%0d got=%h exp=%h", cyc, ipg_tx_data, e); end
        total++; if (grant !== ((kind_q.pop_front() == 2) ? 2'd3 : 2'(s))) begin
          bad++; $display("FAIL cont_grant cyc%0d got=%0d src=%0d", cyc, grant, s); end
      end
      cyc++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cont_timeout left=%0d exp=0", exp_q.size()); end
    req_valid = '0; req_last = '0; ipg_slot = 1'b0;
  endtask

  task automatic test_length_cap();
    logic [PW-1:0] p[6];
    logic [DW-1:0] e;
    int kinds[6];
    int grants[6];
    kinds  = '{0, 1, 1, 2, 0, 2};
    grants = '{0, 0, 0, 3, 0, 3};
    do_reset();
    for (int k = 0; k < 6; k++) p[k] = rnd_pay();
    for (int k = 0; k < 6; k++) begin
      ipg_slot = 1'b1; req_valid = 3'b001; req_last = (k == 5) ? 3'b001 : 3'b000;
      set_pay(0, p[k]);
      tick();
      e = {p[k], exp_type(0, kinds[k])};
      total++; if (ipg_tx_valid !== 1'b1 || ipg_tx_data !== e) begin
        bad++; $display("FAIL cap_blk%0d got=%b/%h exp=1/%h", k, ipg_tx_valid, ipg_tx_data, e); end
      total++; if (err_sticky !== (k >= 3) || grant !== 2'(grants[k])) begin
        bad++; $display("FAIL cap_state%0d got err=%b grant=%0d exp err=%b grant=%0d", k, err_sticky, grant, k >= 3, grants[k]); end
    end
    req_valid = '0; req_last = '0; ipg_slot = 1'b0;
  endtask

  task automatic test_single_block();
    logic [PW-1:0] p;
    logic [DW-1:0] e;
    do_reset();
    p = rnd_pay();
    ipg_slot = 1'b1; req_valid = 3'b010; req_last = 3'b010; set_pay(1, p);
    tick();
    e = {p, exp_type(1, 0)};
    total++; if (ipg_tx_valid !== 1'b1 || ipg_tx_data !== e) begin
      bad++; $display("FAIL sblk_data got=%b/%h exp=1/%h", ipg_tx_valid, ipg_tx_data, e); end
    total++; if (err_sticky !== 1'b1 || grant !== 2'd3) begin
      bad++; $display("FAIL sblk_state got err=%b grant=%0d exp err=1 grant=3", err_sticky, grant); end
    req_valid = '0; req_last = '0; ipg_slot = 1'b0;
  endtask

  task automatic test_stall_abort();
    logic [PW-1:0] p, q0, q1;
    logic [DW-1:0] e;
    do_reset();
    p = rnd_pay(); q0 = rnd_pay(); q1 = rnd_pay();
    ipg_slot = 1'b1; req_valid = 3'b100; req_last = '0; set_pay(2, p);
    tick();
    e = {p, exp_type(2, 0)};
    total++; if (ipg_tx_data !== e || grant !== 2'd2) begin
      bad++; $display("FAIL stall_first got=%h/%0d exp=%h/2", ipg_tx_data, grant, e); end
    for (int c = 1; c <= 3; c++) begin
      req_valid = 3'b001; set_pay(0, q0);
      #1;
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL stall_ready%0d got=%b exp=000", c, req_ready); end
      tick();
      total++; if (abort !== (c == 3) || grant !== ((c == 3) ? 2'd3 : 2'd2) || ipg_tx_valid !== 1'b0) begin
        bad++; $display("FAIL stall_cyc%0d got abort=%b grant=%0d valid=%b exp abort=%b", c, abort, grant, ipg_tx_valid, c == 3); end
    end
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL stall_next_ready got=%b exp=001", req_ready); end
    tick();
    e = {q0, exp_type(0, 0)};
    total++; if (abort !== 1'b0 || grant !== 2'd0 || ipg_tx_data !== e) begin
      bad++; $display("FAIL stall_next got abort=%b grant=%0d data=%h exp 0/0/%h", abort, grant, ipg_tx_data, e); end
    req_last = 3'b001; set_pay(0, q1);
    tick();
    e = {q1, exp_type(0, 2)};
    total++; if (ipg_tx_data !== e || grant !== 2'd3) begin
      bad++; $display("FAIL stall_last got=%h/%0d exp=%h/3", ipg_tx_data, grant, e); end
    req_valid = '0; req_last = '0; ipg_slot = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] p[5];
    logic [DW-1:0] e;
    do_reset();
    for (int k = 0; k < 5; k++) p[k] = rnd_pay();
    for (int k = 0; k < 2; k++) begin
      ipg_slot = 1'b1; req_valid = 3'b100; req_last = '0; set_pay(2, p[k]);
      tick();
      e = {p[k], exp_type(2, k)};
      total++; if (ipg_tx_data !== e) begin bad++; $display("FAIL rmid_blk%0d got=%h exp=%h", k, ipg_tx_data, e); end
    end
    reset = 1'b1; set_pay(2, p[2]);
    tick();
    total++; if (ipg_tx_data !== '0 || ipg_tx_valid !== 1'b0 || grant !== 2'd3 || abort !== 1'b0 || err_sticky !== 1'b0) begin
      bad++; $display("FAIL rmid_reset got data=%h valid=%b grant=%0d abort=%b err=%b exp 0/0/3/0/0",
                      ipg_tx_data, ipg_tx_valid, grant, abort, err_sticky); end
    reset = 1'b0;
    tick();
    e = {p[2], exp_type(2, 0)};
    total++; if (ipg_tx_data !== e || grant !== 2'd2) begin
      bad++; $display("FAIL rmid_restart got=%h/%0d exp=%h/2", ipg_tx_data, grant, e); end
    req_last = 3'b100; set_pay(2, p[3]);
    tick();
    e = {p[3], exp_type(2, 2)};
    total++; if (ipg_tx_data !== e || grant !== 2'd3) begin
      bad++; $display("FAIL rmid_last got=%h/%0d exp=%h/3", ipg_tx_data, grant, e); end
    req_valid = '0; req_last = '0; ipg_slot = 1'b0;
  endtask

  task automatic test_random(input int iter);
    logic [PW-1:0] pay[3][12];
    logic          lastf[3][12];
    int            mlen[3][3];
    int            nmsg[3], nblk[3], sent[3], mi[3], base[3];
    logic [DW-1:0] exp_q[$];
    int            ptr, s, cyc, kind;
    logic [2:0]    rdy;
    logic          cur_slot;
    logic [DW-1:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      nmsg[i] = $urandom_range(1, 3); nblk[i] = 0; sent[i] = 0; mi[i] = 0; base[i] = 0;
      for (int m = 0; m < nmsg[i]; m++) begin
        mlen[i][m] = $urandom_range(2, MAXB);
        for (int b = 0; b < mlen[i][m]; b++) begin
          pay[i][nblk[i]] = rnd_pay();
          lastf[i][nblk[i]] = (b == mlen[i][m] - 1);
          nblk[i]++;
        end
      end
    end
    // Sources stay valid while they have blocks, so message order is pure round-robin.
    ptr = 0;
    while (mi[0] < nmsg[0] || mi[1] < nmsg[1] || mi[2] < nmsg[2]) begin
      s = -1;
      for (int k = 0; k < 3; k++) if (s < 0 && mi[(ptr + k) % 3] < nmsg[(ptr + k) % 3]) s = (ptr + k) % 3;
      for (int b = 0; b < mlen[s][mi[s]]; b++) begin
        kind = (b == 0) ? 0 : (b == mlen[s][mi[s]] - 1) ? 2 : 1;
        exp_q.push_back({pay[s][base[s] + b], exp_type(s, kind)});
      end
      base[s] += mlen[s][mi[s]]; mi[s]++; ptr = (s + 1) % 3;
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 1000) begin
      ipg_slot = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 3; i++) begin
        req_valid[i] = (sent[i] < nblk[i]);
        req_last[i]  = (sent[i] < nblk[i]) ? lastf[i][sent[i]] : 1'b0;
        if (sent[i] < nblk[i]) set_pay(i, pay[i][sent[i]]);
      end
      cur_slot = ipg_slot;
      #1;
      rdy = req_ready;
      total++; if (!$onehot0(rdy) || (rdy & ~req_valid) != 3'b000 || (!cur_slot && rdy != 3'b000)) begin
        bad++; $display("FAIL rnd%0d_ready cyc%0d got=%b valid=%b slot=%b", iter, cyc, rdy, req_valid, cur_slot); end
      tick();
      for (int i = 0; i < 3; i++) if (rdy[i]) sent[i]++;
      if (ipg_tx_valid) begin
        e = exp_q.pop_front();
        total++; if (ipg_tx_data !== e || !cur_slot) begin
          bad++; $display("FAIL rnd%0d_blk cyc%0d got=%h exp=%h slot=%b", iter, cyc, ipg_tx_data, e, cur_slot); end
      end
      total++; if (abort !== 1'b0) begin bad++; $display("FAIL rnd%0d_abort cyc%0d got=%b exp=0", iter, cyc, abort); end
      cyc++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd%0d_timeout left=%0d exp=0", iter, exp_q.size()); end
    ipg_slot = 1'b1; req_valid = '0; req_last = '0;
    tick();
    total++; if (ipg_tx_valid !== 1'b0 || err_sticky !== 1'b0) begin
      bad++; $display("FAIL rnd%0d_tail got valid=%b err=%b exp 0/0", iter, ipg_tx_valid, err_sticky); end
    ipg_slot = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ipg_slot = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    test_reset();
    test_single_source();
    test_slot_gating();
    test_contention();
    test_length_cap();
    test_single_block();
    test_stall_abort();
    test_reset_mid();
    for (int i = 0; i < 4; i++) test_random(i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipg_msg_arbiter.md
Name: ipg_msg_arbiter

Overview:
- Shares the single IPG transmit slot stream between three message sources: read requests, read responses and write requests.
- Each source presents 56-bit payload blocks. The arbiter grants one source per message and prepends the block-type byte (FIRST/middle/LAST per message class). It emits 64-bit IPG blocks only when the PHY offers an idle slot.
- Sits upstream of the TX IPG inserter and feeds the receive-side request processors on the far end.
- Never interleaves blocks of different messages.

Parameters:
- DATA_WIDTH, 64, IPG block width (payload is DATA_WIDTH-8).
- MAX_BLKS, 16, maximum blocks per message, FIRST and LAST included.
- STALL_MAX, 255, idle-slot cycles a granted source may leave unused before abort.
- CNT_W, 8, width of the block and stall counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ipg_slot  in  1  PHY offers an IPG slot this cycle.
- req_valid  in  3  per source: [0]=READ, [1]=RRESP, [2]=WRITE.
- req_data  in  3x56  payload blocks, flattened; source i uses bits [56*i+55:56*i].
- req_last  in  3  marks the final block of a message.
- req_ready  out  3  block accepted this cycle (combinational).
- ipg_tx_data  out  64  {payload[55:0], block_type[7:0]}.
- ipg_tx_valid  out  1  ipg_tx_data holds a new block.
- grant  out  2  current owner: 0, 1 or 2; 3 when idle.
- abort  out  1  one-cycle pulse when a message is aborted.
- err_sticky  out  1  protocol error seen; cleared only by reset.

Behaviour:
- Reset values:
  - ipg_tx_data=0, ipg_tx_valid=0, grant=3, abort=0, err_sticky=0.
  - Round-robin pointer = 0 (READ has first priority).
  - blk_cnt=0, stall_cnt=0, state=IDLE.
  - Reset mid-message drops the message with no LAST emitted; the receiver resynchronises on the next FIRST.
- IDLE:
  - When ipg_slot=1 and any req_valid=1, pick the first valid source at or after the RR pointer (order 0→1→2→0).
  - The first block is accepted in the same cycle: req_ready[sel]=1.
  - Move to BUSY with grant=sel and blk_cnt=1.
  - With no ipg_slot, or no valid source: stay in IDLE, all req_ready=0.
- BUSY:
  - req_ready[grant] = ipg_slot & req_valid[grant]; every other req_ready is 0.
  - Each accepted block increments blk_cnt and clears stall_cnt.
  - When the accepted block has req_last=1, return to IDLE, set the RR pointer to grant+1 (mod 3), and set grant=3.
- Block type encoding, class nibble a/b/c for source 0/1/2:
  - First block: 0x0a, 0x0b or 0x0c.
  - Middle blocks: 0x1a, 0x1b or 0x1c.
  - Last block: 0x2a, 0x2b or 0x2c.
- Output timing:
  - Registered output, latency 1: an accepted block in cycle N appears on ipg_tx_data with ipg_tx_valid=1 in cycle N+1.
  - ipg_tx_valid is low in every cycle after which no block was accepted.
  - ipg_tx_data holds its last value while ipg_tx_valid=0.
- Single-block message (req_last=1 on the first block):
  - Encode the block as FIRST, set err_sticky, release the grant.
  - A message needs at least 2 blocks.
- Length limit:
  - The block at blk_cnt==MAX_BLKS-1 is forced to LAST type whatever req_last says.
  - If req_last=0 on that block, set err_sticky.
  - Return to IDLE; the source's remaining blocks compete as a new message.
- Stall:
  - In BUSY, a cycle with ipg_slot=1 and req_valid[grant]=0 increments stall_cnt.
  - Cycles without ipg_slot do not count.
  - When stall_cnt reaches STALL_MAX: pulse abort, go to IDLE, advance the RR pointer, emit nothing.
  - The receiver detects the truncated message when the next FIRST arrives.
- Simultaneous events:
  - LAST accepted in the same cycle another source raises valid: the other source can win only from the next cycle; IDLE lasts at least 1 cycle between messages.
  - Stall expiry and an accept in the same cycle are impossible: accept implies valid.
- Counter width rule: CNT_W must satisfy 2^CNT_W > max(MAX_BLKS, STALL_MAX); this is checked by an elaboration assertion.

Decomposition:
- Shared package ipg_pkg: block-type localparams (READFIRST..WRITLAST: 0x0a–0x2c), source indices SRC_READ=0, SRC_RRESP=1, SRC_WRITE=2, and GRANT_NONE=3. The request processors and the TX inserter use the same package.
- One sub-module, ipg_rr_pick: 3-way round-robin selector, purely combinational; pointer in, valid vector in, select and any out.
- The FSM, counters and output register stay in the top module.

Test Plan:
- Single source: WRITE sends 4 blocks, ipg_slot=1 every cycle → tx blocks 0x…0c, 0x…1c, 0x…1c, 0x…2c on 4 consecutive cycles, first one a cycle after the first accept; grant 2→3.
- Contention: all three valid with 2-block messages, pointer=0 → message order READ, RRESP, WRITE, no interleaving; second round starts at READ again; one IDLE cycle between messages.
- Slot gating: ipg_slot toggles 1,0,1,0 during a 3-block RRESP → req_ready and ipg_tx_valid only follow slot cycles; types 0b, 1b, 2b.
- Length cap: MAX_BLKS=4, READ streams 6 blocks with req_last only on the 6th → 0a, 1a, 1a, 2a, err_sticky=1, then the message restarts as 0a, 2a.
- Stall abort: STALL_MAX=3, WRITE sends FIRST then drops valid with ipg_slot=1 → abort pulses 3 slot-cycles later, grant=3, and a waiting READ is granted next.
- Reset mid-message: reset asserted after the 2nd block of a 5-block write → next cycle all outputs at reset values; after release the next message begins with a FIRST type.
